// File: rtl/key_debounce_pkg.sv
// Board-level constants and shared types for the push-button input chain.
package key_debounce_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam logic        KEY_ACTIVE_LEVEL = 1'b0;
    localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 50;
    localparam int unsigned NUM_KEYS         = 4;

    localparam int unsigned KEY_INC = 0;
    localparam int unsigned KEY_DEC = 1;
    localparam int unsigned KEY_CLR = 2;
    localparam int unsigned KEY_AUX = 3;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_e;

endpackage

// File: rtl/key_debounce_key_filter.sv
// One key: two-flop synchronizer, stability counter and RELEASED/PRESSED filter
// with single-cycle press/release pulses.
module key_filter
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             synced;
    logic             differs;
    key_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= '1;
            state         <= RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[0], key_raw};
            state         <= state_n;
            cnt           <= cnt_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    assign synced  = (sync[1] == KEY_ACTIVE_LEVEL);
    assign differs = (synced != (state == PRESSED));
    assign level   = (state == PRESSED);

    // Any agreeing cycle restarts the window, so only an unbroken run flips state.
    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        press_n   = 1'b0;
        release_n = 1'b0;
        if (differs) begin
            if (cnt == CNT_LAST) begin
                press_n   = (state == RELEASED);
                release_n = (state == PRESSED);
                state_n   = (state == RELEASED) ? PRESSED : RELEASED;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces the four active-low board keys and drives the COUNT value register
// from the accepted press pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    output logic [3:0] KEY_STATE,
    output logic [3:0] KEY_PRESS,
    output logic [3:0] KEY_RELEASE,
    output logic [3:0] COUNT
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_filter (
            .clk          (CLK),
            .rst          (RST),
            .key_raw      (KEY[i]),
            .level        (KEY_STATE[i]),
            .press_pulse  (KEY_PRESS[i]),
            .release_pulse(KEY_RELEASE[i])
        );
    end

    logic inc, dec;
    assign inc = KEY_PRESS[KEY_INC] & ~KEY_PRESS[KEY_DEC];
    assign dec = KEY_PRESS[KEY_DEC] & ~KEY_PRESS[KEY_INC];

    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= '0;
        end else if (KEY_PRESS[KEY_CLR]) begin
            COUNT <= '0;
        end else if (inc) begin
            COUNT <= COUNT + 4'd1;
        end else if (dec) begin
            COUNT <= COUNT - 4'd1;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce at DEBOUNCE_CYCLES = 8: table vectors, directed corner
// sequences and random key activity against a sliding-window reference model.
module tb_key_debounce;

    localparam int unsigned DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] key_state, key_press, key_release, count;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .KEY        (key),
        .KEY_STATE  (key_state),
        .KEY_PRESS  (key_press),
        .KEY_RELEASE(key_release),
        .COUNT      (count)
    );

    always #5 clk = ~clk;

    // Reference: a key is accepted once its last DC synchronized samples all
    // disagree with the accepted level; samples reach the filter two edges late.
    logic [3:0]    m_d1, m_d2;
    logic [DC-1:0] m_hist [4];
    logic [3:0]    m_state, m_press, m_rel, m_count;

    task automatic model_edge();
        logic [3:0] np, nr, cnt_next;
        logic       s, flip;
        if (rst) begin
            m_d1 = 4'hF; m_d2 = 4'hF;
            for (int k = 0; k < 4; k++) m_hist[k] = '0;
            m_state = '0; m_press = '0; m_rel = '0; m_count = '0;
        end else begin
            cnt_next = m_count;
            if (m_press[2])                  cnt_next = 4'd0;
            else if (m_press[0] && !m_press[1]) cnt_next = 4'(m_count + 4'd1);
            else if (m_press[1] && !m_press[0]) cnt_next = 4'(m_count - 4'd1);
            np = '0; nr = '0;
            for (int k = 0; k < 4; k++) begin
                s         = (m_d2[k] == 1'b0);
                m_hist[k] = {m_hist[k][DC-2:0], s};
                flip      = m_state[k] ? (m_hist[k] == '0) : (m_hist[k] == '1);
                np[k]     = flip && !m_state[k];
                nr[k]     = flip && m_state[k];
                if (flip) m_state[k] = ~m_state[k];
            end
            m_press = np; m_rel = nr; m_count = cnt_next;
            m_d2 = m_d1; m_d1 = key;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_state",   int'(key_state),   int'(m_state));
        chk("model_press",   int'(key_press),   int'(m_press));
        chk("model_release", int'(key_release), int'(m_rel));
        chk("model_count",   int'(count),       int'(m_count));
        chk("press_release_overlap", int'(key_press & key_release), 0);
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic wait_pulse(input int unsigned idx, input bit is_press, output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if ((is_press ? key_press[idx] : key_release[idx]) == 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  key;
        int unsigned hold;
        logic [3:0]  state;
        logic [3:0]  count;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses;
        logic [3:0] saved;

        vecs[0]  = '{4'hF, 14, 4'b0000, 4'd0};
        vecs[1]  = '{4'hE, 14, 4'b0001, 4'd1};
        vecs[2]  = '{4'hF, 14, 4'b0000, 4'd1};
        vecs[3]  = '{4'hD, 14, 4'b0010, 4'd0};
        vecs[4]  = '{4'hF, 14, 4'b0000, 4'd0};
        vecs[5]  = '{4'hD, 14, 4'b0010, 4'd15};
        vecs[6]  = '{4'hF, 14, 4'b0000, 4'd15};
        vecs[7]  = '{4'hE, 14, 4'b0001, 4'd0};
        vecs[8]  = '{4'hF, 14, 4'b0000, 4'd0};
        vecs[9]  = '{4'h7, 14, 4'b1000, 4'd0};
        vecs[10] = '{4'hF, 14, 4'b0000, 4'd0};
        vecs[11] = '{4'hC, 14, 4'b0011, 4'd0};
        vecs[12] = '{4'hF, 14, 4'b0000, 4'd0};

        // Reset held three cycles, then idle.
        rst = 1'b1; key = 4'hF;
        steps(3);
        chk("reset_state",   int'(key_state),   0);
        chk("reset_press",   int'(key_press),   0);
        chk("reset_release", int'(key_release), 0);
        chk("reset_count",   int'(count),       0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += $countones(key_press) + $countones(key_release);
        end
        chk("idle_pulses", pulses, 0);

        // Clean press and release of KEY[0].
        key = 4'hE;
        wait_pulse(0, 1'b1, lat);
        chk_range("press_latency", lat, 9, 11);
        step();
        chk("press_width", int'(key_press[0]), 0);
        chk("press_count", int'(count), 1);
        chk("press_level", int'(key_state[0]), 1);
        steps(4);
        key = 4'hF;
        wait_pulse(0, 1'b0, lat);
        chk_range("release_latency", lat, 9, 11);
        steps(3);
        chk("release_count", int'(count), 1);

        // Bounce on KEY[1] with 5-cycle runs.
        pulses = 0;
        for (int r = 0; r < 6; r++) begin
            key = 4'hD;
            for (int i = 0; i < 5; i++) begin step(); pulses += $countones(key_press | key_release); end
            key = 4'hF;
            for (int i = 0; i < 5; i++) begin step(); pulses += $countones(key_press | key_release); end
        end
        for (int i = 0; i < 15; i++) begin step(); pulses += $countones(key_press | key_release); end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_level", int'(key_state[1]), 0);
        chk("bounce_count", int'(count), 1);

        // Table vectors from a fresh reset (covers wrap both ways and KEY[3]).
        rst = 1'b1; step(); rst = 1'b0;
        foreach (vecs[i]) begin
            key = vecs[i].key;
            steps(vecs[i].hold);
            chk("vec_state", int'(key_state), int'(vecs[i].state));
            chk("vec_count", int'(count),     int'(vecs[i].count));
        end

        // Simultaneous INC and DEC presses.
        saved = count;
        key = 4'hC;
        wait_pulse(0, 1'b1, lat);
        chk("simul_pulses", int'(key_press), 3);
        steps(4);
        chk("simul_count", int'(count), int'(saved));
        key = 4'hF; steps(14);

        // Build COUNT = 5, then CLR together with INC.
        for (int p = 0; p < 5; p++) begin
            key = 4'hE; steps(14);
            key = 4'hF; steps(14);
        end
        chk("count_five", int'(count), 5);
        key = 4'hA; steps(14);
        chk("clr_priority", int'(count), 0);
        key = 4'hF; steps(14);

        // Reset in the middle of a debounce window, key kept held.
        key = 4'hE;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin step(); pulses += $countones(key_press); end
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_reset_pulses", pulses + $countones(key_press), 0);
        wait_pulse(0, 1'b1, lat);
        chk_range("post_reset_latency", lat, 9, 11);
        step();
        chk("post_reset_count", int'(count), 1);
        key = 4'hF; steps(14);

        // Random key activity with occasional resets.
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            key = 4'($urandom_range(0, 15));
            steps($urandom_range(1, 14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
